// File: rtl/instr_fetch_unit.sv
// Fetch stage for the single-cycle MIPS core: PC, host-loadable instruction memory,
// and a saturating retired-instruction counter.
module instr_fetch_unit #(
    parameter int unsigned ADDR_W    = 6,
    parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF,
    parameter int unsigned CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_we,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [31:0]       load_data,
    input  logic              start,
    input  logic              stall,
    output logic [31:0]       instruction,
    output logic [31:0]       pc,
    output logic              instr_valid,
    output logic              halted,
    output logic [CNT_W-1:0]  retired
);

    typedef enum logic [1:0] {StIdle, StRun, StHalt} state_e;

    localparam int unsigned Depth  = 1 << ADDR_W;
    localparam logic [31:0] LastPc = 32'((Depth - 1) * 4);

    logic [31:0]       mem [Depth];
    state_e            state_q, state_d;
    logic [31:0]       pc_q, pc_d;
    logic [CNT_W-1:0]  retired_q, retired_d;
    logic [ADDR_W-1:0] word_addr;
    logic [31:0]       cur_word;

    assign word_addr = pc_q[ADDR_W+1:2];
    assign cur_word  = mem[word_addr];

    // Memory is not reset; the host may only write it while the core is not running.
    always_ff @(posedge clk) begin
        if (load_we && (state_q != StRun)) begin
            mem[load_addr] <= load_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            pc_q      <= '0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            retired_q <= retired_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        retired_d = retired_q;
        case (state_q)
            StIdle, StHalt: begin
                if (start) begin
                    state_d   = StRun;
                    pc_d      = '0;
                    retired_d = '0;
                end
            end
            StRun: begin
                if (cur_word == HALT_WORD) begin
                    state_d = StHalt;
                end else if (!stall) begin
                    if (retired_q != '1) begin
                        retired_d = retired_q + CNT_W'(1);
                    end
                    // The last word retires but the PC parks there instead of wrapping.
                    if (pc_q == LastPc) begin
                        state_d = StHalt;
                    end else begin
                        pc_d = pc_q + 32'd4;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        instruction = '0;
        instr_valid = 1'b0;
        halted      = 1'b0;
        case (state_q)
            StRun: begin
                instr_valid = 1'b1;
                instruction = cur_word;
            end
            StHalt:  halted = 1'b1;
            default: ;
        endcase
    end

    assign pc      = pc_q;
    assign retired = retired_q;

endmodule
